// File: rtl/pid_input_scheduler.sv
// pid_input_scheduler: round-robin issue of per-channel samples
// into a shared PID datapath with a per-channel cooldown.
module pid_input_scheduler #(
  parameter int N_CHAN  = 8,
  parameter int W_CHAN  = 5,
  parameter int W_DIN   = 18,
  parameter int MIN_GAP = 6
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    en_in,
  input  logic [N_CHAN-1:0]       chan_en_in,
  input  logic [N_CHAN-1:0]       samp_dv_in,
  input  logic [N_CHAN*W_DIN-1:0] samp_data_in,
  input  logic                    ovr_clr_in,
  output logic                    dv_out,
  output logic [W_CHAN-1:0]       chan_out,
  output logic [W_DIN-1:0]        data_out,
  output logic [N_CHAN-1:0]       ovr_out,
  output logic                    busy_out
);

  localparam int W_COOL =
    (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [W_COOL-1:0] COOL_LD =
    W_COOL'(MIN_GAP - 1);
  localparam logic [W_CHAN-1:0] LAST =
    W_CHAN'(N_CHAN - 1);

  logic [W_DIN-1:0]  hold [N_CHAN];
  logic [W_COOL-1:0] cool [N_CHAN];
  logic [N_CHAN-1:0] pend;
  logic [N_CHAN-1:0] elig;
  logic [N_CHAN-1:0] gnt_oh;
  logic [W_CHAN-1:0] ptr;
  logic [W_CHAN-1:0] ptr_nxt;
  logic [W_CHAN-1:0] gnt_idx;
  logic [W_CHAN-1:0] hi_idx;
  logic [W_CHAN-1:0] lo_idx;
  logic              hi_v;
  logic              lo_v;
  logic              gnt_v;
  logic [W_DIN-1:0]  gnt_data;

  assign busy_out = |pend;

  always_comb begin
    for (int k = 0; k < N_CHAN; k++) begin
      elig[k] = en_in & chan_en_in[k] & pend[k]
              & (cool[k] == '0);
    end
  end

  // Descending scan: last hit is the lowest index,
  // both overall and among indices at/after ptr.
  always_comb begin
    hi_v   = 1'b0;
    hi_idx = '0;
    lo_v   = 1'b0;
    lo_idx = '0;
    for (int i = N_CHAN - 1; i >= 0; i--) begin
      if (elig[i]) begin
        lo_v   = 1'b1;
        lo_idx = W_CHAN'(i);
        if (W_CHAN'(i) >= ptr) begin
          hi_v   = 1'b1;
          hi_idx = W_CHAN'(i);
        end
      end
    end
    gnt_v   = lo_v;
    gnt_idx = hi_v ? hi_idx : lo_idx;
    ptr_nxt = (gnt_idx == LAST) ? '0
            : gnt_idx + W_CHAN'(1);
  end

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < N_CHAN; i++) begin
      gnt_oh[i] = gnt_v & (gnt_idx == W_CHAN'(i));
      if (gnt_oh[i]) gnt_data = hold[i];
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      dv_out   <= 1'b0;
      chan_out <= '0;
      data_out <= '0;
      ptr      <= '0;
      pend     <= '0;
      ovr_out  <= '0;
      for (int k = 0; k < N_CHAN; k++) begin
        hold[k] <= '0;
        cool[k] <= '0;
      end
    end else begin
      dv_out <= gnt_v;
      if (gnt_v) begin
        chan_out <= gnt_idx;
        data_out <= gnt_data;
        ptr      <= ptr_nxt;
      end
      for (int k = 0; k < N_CHAN; k++) begin
        if (gnt_oh[k])
          cool[k] <= COOL_LD;
        else if (cool[k] != '0)
          cool[k] <= cool[k] - W_COOL'(1);

        // A grant in the arrival cycle absorbs the old
        // sample, so only an ungranted hit overruns.
        if (chan_en_in[k] & samp_dv_in[k]
            & pend[k] & ~gnt_oh[k])
          ovr_out[k] <= 1'b1;
        else if (ovr_clr_in)
          ovr_out[k] <= 1'b0;

        if (!chan_en_in[k]) begin
          pend[k] <= 1'b0;
        end else if (samp_dv_in[k]) begin
          pend[k] <= 1'b1;
          hold[k] <= samp_data_in[k*W_DIN +: W_DIN];
        end else if (gnt_oh[k]) begin
          pend[k] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pid_input_scheduler.sv
// tb_pid_input_scheduler: directed scenarios plus randomized
// traffic checked against a cycle-level reference model.
module tb_pid_input_scheduler;

  localparam int N  = 8;
  localparam int WC = 5;
  localparam int WD = 18;
  localparam int MG = 6;

  logic            clk_in = 1'b0;
  logic            rst_n_in;
  logic            en_in;
  logic [N-1:0]    chan_en_in;
  logic [N-1:0]    samp_dv_in;
  logic [N*WD-1:0] samp_data_in;
  logic            ovr_clr_in;
  logic            dv_out;
  logic [WC-1:0]   chan_out;
  logic [WD-1:0]   data_out;
  logic [N-1:0]    ovr_out;
  logic            busy_out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bit            m_pend [N];
  logic [WD-1:0] m_hold [N];
  int            m_cool [N];
  logic [N-1:0]  m_ovr  = '0;
  int            m_ptr  = 0;
  logic          m_dv   = 1'b0;
  logic [WC-1:0] m_chan = '0;
  logic [WD-1:0] m_data = '0;

  pid_input_scheduler #(
    .N_CHAN(N), .W_CHAN(WC),
    .W_DIN(WD), .MIN_GAP(MG)
  ) dut (
    .clk_in(clk_in),
    .rst_n_in(rst_n_in),
    .en_in(en_in),
    .chan_en_in(chan_en_in),
    .samp_dv_in(samp_dv_in),
    .samp_data_in(samp_data_in),
    .ovr_clr_in(ovr_clr_in),
    .dv_out(dv_out),
    .chan_out(chan_out),
    .data_out(data_out),
    .ovr_out(ovr_out),
    .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic model_step();
    int g;
    int k;
    if (!rst_n_in) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 0;
        m_hold[i] = '0;
        m_cool[i] = 0;
      end
      m_ovr = '0; m_ptr = 0;
      m_dv = 1'b0; m_chan = '0; m_data = '0;
      return;
    end
    g = -1;
    for (int i = 0; i < N && g < 0; i++) begin
      k = (m_ptr + i) % N;
      if (en_in && chan_en_in[k] && m_pend[k]
          && m_cool[k] == 0)
        g = k;
    end
    m_dv = (g >= 0);
    if (g >= 0) begin
      m_chan = WC'(g);
      m_data = m_hold[g];
      m_ptr  = (g + 1) % N;
    end
    if (ovr_clr_in) m_ovr = '0;
    for (int i = 0; i < N; i++) begin
      if (chan_en_in[i] && samp_dv_in[i]
          && m_pend[i] && i != g)
        m_ovr[i] = 1'b1;
      if (i == g) m_cool[i] = MG - 1;
      else if (m_cool[i] > 0) m_cool[i]--;
      if (!chan_en_in[i]) m_pend[i] = 0;
      else if (samp_dv_in[i]) begin
        m_pend[i] = 1;
        m_hold[i] = samp_data_in[i*WD +: WD];
      end else if (i == g) m_pend[i] = 0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_in);
    #1;
    cyc++;
  endtask

  task automatic set_samp(input int k,
                          input logic [WD-1:0] v);
    samp_dv_in[k] = 1'b1;
    samp_data_in[k*WD +: WD] = v;
  endtask

  task automatic idle(input int n);
    samp_dv_in = '0;
    ovr_clr_in = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0; en_in = 1'b1;
    chan_en_in = '1; samp_dv_in = '0;
    samp_data_in = '0; ovr_clr_in = 1'b0;
    tick(); tick();
    total++;
    if (dv_out !== 1'b0 || chan_out !== '0
        || data_out !== '0) begin
      bad++;
      $display("FAIL reset_out dv=%b ch=%0d d=%h want 0",
               dv_out, chan_out, data_out);
    end
    total++;
    if (ovr_out !== '0 || busy_out !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags ovr=%h busy=%b want 0",
               ovr_out, busy_out);
    end
    rst_n_in = 1'b1;
    tick();
  endtask

  task automatic test_single();
    set_samp(3, 18'h1F00);
    tick();
    samp_dv_in = '0;
    total++;
    if (dv_out !== 1'b0 || busy_out !== 1'b1) begin
      bad++;
      $display("FAIL single_t1 dv=%b busy=%b want 0/1",
               dv_out, busy_out);
    end
    tick();
    total++;
    if (dv_out !== 1'b1 || chan_out !== 5'd3
        || data_out !== 18'h1F00) begin
      bad++;
      $display("FAIL single_t2 dv=%b ch=%0d d=%h want 1/3/1f00",
               dv_out, chan_out, data_out);
    end
    tick();
    total++;
    if (dv_out !== 1'b0) begin
      bad++;
      $display("FAIL single_t3 dv=%b want 0", dv_out);
    end
    idle(8);
  endtask

  task automatic test_multi();
    logic [WC-1:0] exp_ch [3];
    exp_ch[0] = 5'd0; exp_ch[1] = 5'd2; exp_ch[2] = 5'd7;
    rst_n_in = 1'b0; tick(); rst_n_in = 1'b1;
    set_samp(0, 18'h00011);
    set_samp(2, 18'h00022);
    set_samp(7, 18'h3FF77);
    tick();
    samp_dv_in = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (dv_out !== 1'b1 || chan_out !== exp_ch[i]
          || data_out !== m_data) begin
        bad++;
        $display("FAIL multi_%0d dv=%b ch=%0d d=%h want 1/%0d/%h",
                 i, dv_out, chan_out, data_out,
                 exp_ch[i], m_data);
      end
    end
    total++;
    if (dut.ptr !== 5'd0) begin
      bad++;
      $display("FAIL multi_ptr ptr=%0d want 0", dut.ptr);
    end
    idle(8);
  endtask

  task automatic test_overrun();
    int hits [$];
    for (int i = 0; i < 30; i++) begin
      set_samp(1, WD'($urandom));
      tick();
      if (dv_out === 1'b1 && chan_out === 5'd1)
        hits.push_back(cyc);
      total++;
      if (dv_out !== m_dv || data_out !== m_data) begin
        bad++;
        $display("FAIL ovr_data dv=%b d=%h want %b/%h",
                 dv_out, data_out, m_dv, m_data);
      end
    end
    samp_dv_in = '0;
    total++;
    if (hits.size() != 5) begin
      bad++;
      $display("FAIL ovr_pulses n=%0d want 5", hits.size());
    end
    for (int i = 1; i < hits.size(); i++) begin
      total++;
      if (hits[i] - hits[i-1] != MG) begin
        bad++;
        $display("FAIL ovr_gap gap=%0d want %0d",
                 hits[i] - hits[i-1], MG);
      end
    end
    total++;
    if (ovr_out[1] !== 1'b1) begin
      bad++;
      $display("FAIL ovr_flag ovr=%h want bit1", ovr_out);
    end
    idle(8);
  endtask

  task automatic test_ovr_clr();
    en_in = 1'b0;
    set_samp(4, 18'h0A0A0);
    tick();
    set_samp(4, 18'h0B0B0);
    tick();
    total++;
    if (ovr_out !== 8'h12) begin
      bad++;
      $display("FAIL clr_pre ovr=%h want 12", ovr_out);
    end
    set_samp(4, 18'h0C0C0);
    ovr_clr_in = 1'b1;
    tick();
    samp_dv_in = '0;
    ovr_clr_in = 1'b0;
    total++;
    if (ovr_out !== 8'h10) begin
      bad++;
      $display("FAIL clr_set_wins ovr=%h want 10", ovr_out);
    end
    en_in = 1'b1;
    tick();
    total++;
    if (dv_out !== 1'b1 || chan_out !== 5'd4
        || data_out !== 18'h0C0C0) begin
      bad++;
      $display("FAIL clr_issue dv=%b ch=%0d d=%h want 1/4/0c0c0",
               dv_out, chan_out, data_out);
    end
    idle(8);
  endtask

  task automatic test_enable();
    en_in = 1'b0;
    set_samp(5, 18'h2ABCD);
    tick();
    samp_dv_in = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (dv_out !== 1'b0 || busy_out !== 1'b1) begin
        bad++;
        $display("FAIL en_hold dv=%b busy=%b want 0/1",
                 dv_out, busy_out);
      end
    end
    en_in = 1'b1;
    tick();
    total++;
    if (dv_out !== 1'b1 || chan_out !== 5'd5
        || data_out !== 18'h2ABCD) begin
      bad++;
      $display("FAIL en_resume dv=%b ch=%0d d=%h want 1/5/2abcd",
               dv_out, chan_out, data_out);
    end
    idle(8);
  endtask

  task automatic test_inflight_reset();
    set_samp(2, 18'h01234);
    tick();
    set_samp(2, 18'h05678);
    tick();
    samp_dv_in = '0;
    total++;
    if (busy_out !== 1'b1 || dv_out !== 1'b1) begin
      bad++;
      $display("FAIL rst_pre busy=%b dv=%b want 1/1",
               busy_out, dv_out);
    end
    rst_n_in = 1'b0;
    tick();
    total++;
    if (dv_out !== 1'b0 || chan_out !== '0
        || data_out !== '0 || ovr_out !== '0
        || busy_out !== 1'b0) begin
      bad++;
      $display("FAIL rst_clear dv=%b ch=%0d d=%h o=%h b=%b want 0",
               dv_out, chan_out, data_out, ovr_out, busy_out);
    end
    rst_n_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (dv_out !== 1'b0) begin
        bad++;
        $display("FAIL rst_no_issue dv=%b ch=%0d want 0",
                 dv_out, chan_out);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      rst_n_in     = ($urandom % 300) != 0;
      en_in        = ($urandom % 8) != 0;
      chan_en_in   = ~N'($urandom & $urandom & $urandom);
      samp_dv_in   = N'($urandom & $urandom);
      ovr_clr_in   = ($urandom % 16) == 0;
      for (int k = 0; k < N; k++)
        samp_data_in[k*WD +: WD] = WD'($urandom);
      tick();
      total++;
      if (dv_out !== m_dv || chan_out !== m_chan
          || data_out !== m_data) begin
        bad++;
        $display("FAIL rnd_out c=%0d got %b/%0d/%h want %b/%0d/%h",
                 cyc, dv_out, chan_out, data_out,
                 m_dv, m_chan, m_data);
      end
      total++;
      if (ovr_out !== m_ovr) begin
        bad++;
        $display("FAIL rnd_ovr c=%0d got %h want %h",
                 cyc, ovr_out, m_ovr);
      end
      total++;
      if (busy_out !== (m_pend.or() != 0)) begin
        bad++;
        $display("FAIL rnd_busy c=%0d got %b want %b",
                 cyc, busy_out, m_pend.or());
      end
    end
    rst_n_in = 1'b1;
    en_in = 1'b1;
    chan_en_in = '1;
    idle(4);
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_overrun();
    test_ovr_clr();
    test_enable();
    test_inflight_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pid_input_scheduler.md
PID_INPUT_SCHEDULER -- requirements
Module: pid_input_scheduler

Interface
REQ-001 SHALL have parameter N_CHAN, default 8, number of sample sources/PID channels.
REQ-002 SHALL have parameter W_CHAN, default 5, channel index width (2^W_CHAN >= N_CHAN).
REQ-003 SHALL have parameter W_DIN, default 18, signed sample width.
REQ-004 SHALL have parameter MIN_GAP, default 6, minimum cycles between issues of the same channel (covers PID filter writeback hazard).
REQ-005 SHALL have port clk_in  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port rst_n_in  input  1  synchronous, active-low reset.
REQ-007 SHALL have port en_in  input  1  global issue enable.
REQ-008 SHALL have port chan_en_in  input  N_CHAN  per-channel enable mask.
REQ-009 SHALL have port samp_dv_in  input  N_CHAN  per-channel sample strobe.
REQ-010 SHALL have port samp_data_in  input  N_CHAN*W_DIN  flattened samples, channel k at bits [k*W_DIN +: W_DIN].
REQ-011 SHALL have port ovr_clr_in  input  1  pulse, clears all overrun flags.
REQ-012 SHALL have port dv_out  output  1  issued sample valid (one-cycle pulse per issue).
REQ-013 SHALL have port chan_out  output  W_CHAN  issued channel index.
REQ-014 SHALL have port data_out  output  W_DIN  issued signed sample.
REQ-015 SHALL have port ovr_out  output  N_CHAN  sticky per-channel overrun flags.
REQ-016 SHALL have port busy_out  output  1  OR of all pending bits.

Function
REQ-017 SHALL keep per channel: hold register (W_DIN), pending bit, cooldown counter (width clog2(MIN_GAP)), overrun flag; plus round-robin pointer ptr (W_CHAN).
REQ-018 SHALL, on samp_dv_in[k]=1 with chan_en_in[k]=1, load hold[k] from its slice and set pend[k] at that edge.
REQ-019 SHALL set ovr[k] when samp_dv_in[k]=1, pend[k]=1 and channel k not granted that cycle; new sample overwrites hold[k].
REQ-020 SHALL, when channel k is granted in the same cycle a new sample arrives, issue the old hold[k], capture the new sample, keep pend[k]=1, not set ovr[k].
REQ-021 SHALL, while chan_en_in[k]=0, ignore samp_dv_in[k] and clear pend[k]; ovr[k] and cooldown unaffected.
REQ-022 SHALL define eligible[k] = en_in & chan_en_in[k] & pend[k] & (cool[k]==0).
REQ-023 SHALL grant at most one channel per cycle: lowest eligible index >= ptr, else lowest eligible index overall (wrap).
REQ-024 SHALL, on grant of k: register dv_out=1, chan_out=k, data_out=hold[k] (visible next cycle); clear pend[k] (except REQ-020); load cool[k]=MIN_GAP-1; set ptr=(k+1) mod N_CHAN.
REQ-025 SHALL drive dv_out=0 and hold chan_out/data_out at last values on cycles with no grant.
REQ-026 SHALL decrement every nonzero cool[k] by 1 per cycle regardless of en_in, giving >= MIN_GAP cycles between same-channel dv_out pulses.
REQ-027 SHALL, with no contention and cool=0, assert dv_out exactly 2 cycles after the samp_dv_in cycle (capture edge, grant/output edge).
REQ-028 SHALL, while en_in=0, make no grants and retain pend and hold contents; issuing resumes the cycle after en_in returns to 1.
REQ-029 SHALL clear all ovr on ovr_clr_in=1; an overrun event in the same cycle sets its flag (set wins).
REQ-030 SHALL compute busy_out combinationally from registered pend bits.

Reset
REQ-031 SHALL, when rst_n_in=0 at a clock edge, clear pend, hold, cool, ovr, ptr, dv_out, chan_out, data_out to 0, overriding all other inputs that cycle.
REQ-032 SHALL discard any sample or grant in flight during reset; first grant possible the cycle after rst_n_in=1 is sampled.

Verification
REQ-033 SHALL cover: single sample ch3=0x1F00 at cycle t, idle -> dv_out=1, chan_out=3, data_out=0x1F00 at t+2 only.
REQ-034 SHALL cover: samples on ch0,ch2,ch7 same cycle, ptr=0 -> issues in order 0,2,7 on consecutive cycles, ptr ends 0.
REQ-035 SHALL cover: ch1 strobed every cycle, MIN_GAP=6 -> ch1 dv_out pulses exactly 6 cycles apart, ovr_out[1]=1.
REQ-036 SHALL cover: ch4 pending, ovr_clr_in and new ch4 overrun same cycle -> ovr_out[4] stays 1.
REQ-037 SHALL cover: en_in=0 with ch5 pending 10 cycles -> no dv_out, busy_out=1; en_in=1 -> ch5 issued next cycle.
REQ-038 SHALL cover: rst_n_in=0 one cycle with ch2 pending and cool nonzero -> all outputs 0, busy_out=0, no later ch2 issue.
